// File: rtl/tune_player.sv
// Piezo tune sequencer: plays fixed note tables on a differential pair
// with rests, looping, abort and busy/done status.
module tune_player #(
  parameter int FAST_SIM   = 1,
  parameter int NUM_TUNES  = 2,
  parameter int MAX_NOTES  = 6,
  parameter int PER_W      = 15,
  parameter int DUR_W      = 25,
  parameter int FAST_SHIFT = 4,
  localparam int TS_W = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [TS_W-1:0] tune_sel,
  input  logic            loop,
  input  logic            abort,
  output logic            piezo,
  output logic            piezo_n,
  output logic            busy,
  output logic            done
);

  localparam int IX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  // FAST_SHIFT only widens the fast-sim step; the default gives 16
  localparam logic [DUR_W-1:0] STEP =
    DUR_W'((FAST_SIM != 0) ? (1 << FAST_SHIFT) : 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  function automatic logic [PER_W-1:0] note_per(
    input logic [TS_W-1:0] t,
    input logic [IX_W-1:0] i
  );
    logic [31:0] p;
    int k;
    k = int'(t) * 64 + int'(i);
    p = 32'd0;
    case (k)
      0:       p = 32'd31888;
      1:       p = 32'd23889;
      2:       p = 32'd18961;
      3:       p = 32'd15944;
      4:       p = 32'd18961;
      5:       p = 32'd15944;
      64:      p = 32'd15944;
      66:      p = 32'd15944;
      default: p = 32'd0;
    endcase
    return p[PER_W-1:0];
  endfunction

  function automatic logic [DUR_W-1:0] note_dur(
    input logic [TS_W-1:0] t,
    input logic [IX_W-1:0] i
  );
    logic [31:0] d;
    int k;
    k = int'(t) * 64 + int'(i);
    d = 32'd0;
    case (k)
      0, 1, 2:    d = 32'd8388608;
      3:          d = 32'd12582912;
      4:          d = 32'd4194304;
      5:          d = 32'd16777216;
      64, 65, 66: d = 32'd4194304;
      default:    d = 32'd0;
    endcase
    return d[DUR_W-1:0];
  endfunction

  // high for the first ceil(P/2) cycles of each period; rests stay low
  function automatic logic tone_hi(
    input logic [PER_W-1:0] p,
    input logic [PER_W-1:0] ph
  );
    logic [PER_W:0] half;
    half = ({1'b0, p} + 1'b1) >> 1;
    return (p != '0) && ({1'b0, ph} < half);
  endfunction

  logic [0:0]       state;
  logic [TS_W-1:0]  tune;
  logic [TS_W-1:0]  ld_tune;
  logic [IX_W-1:0]  idx;
  logic [IX_W-1:0]  nidx;
  logic [IX_W-1:0]  ld_idx;
  logic [PER_W-1:0] pos;
  logic [PER_W-1:0] pos_inc;
  logic [PER_W-1:0] nxt_pos;
  logic [PER_W-1:0] cur_per;
  logic [PER_W-1:0] ld_per;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] ld_dur;
  logic             last_slot;
  logic             tune_end;
  logic             note_last;
  logic             sel_ok;

  always_comb begin
    last_slot = (idx == IX_W'(MAX_NOTES - 1));
    nidx      = last_slot ? '0 : idx + 1'b1;
    tune_end  = last_slot || (note_dur(tune, nidx) == '0);
    note_last = (dur <= STEP);
    cur_per   = note_per(tune, idx);
    pos_inc   = pos + 1'b1;
    nxt_pos   = (pos_inc >= cur_per) ? '0 : pos_inc;
    ld_tune   = (state == S_IDLE) ? tune_sel : tune;
    ld_idx    = ((state == S_IDLE) || tune_end) ? '0 : nidx;
    ld_per    = note_per(ld_tune, ld_idx);
    ld_dur    = note_dur(ld_tune, ld_idx);
    sel_ok    = (int'(tune_sel) < NUM_TUNES);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state   <= S_IDLE;
      tune    <= '0;
      idx     <= '0;
      pos     <= '0;
      dur     <= '0;
      piezo   <= 1'b0;
      piezo_n <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (go && sel_ok) begin
            state   <= S_PLAY;
            tune    <= tune_sel;
            idx     <= '0;
            dur     <= ld_dur;
            pos     <= '0;
            busy    <= 1'b1;
            piezo   <= tone_hi(ld_per, '0);
            piezo_n <= 1'b0;
          end
        end
        (state == S_PLAY): begin
          if (!note_last) begin
            dur     <= dur - STEP;
            pos     <= nxt_pos;
            piezo   <= tone_hi(cur_per, nxt_pos);
            piezo_n <= (cur_per != '0) && !tone_hi(cur_per, nxt_pos);
          end else if (tune_end && !loop) begin
            state   <= S_IDLE;
            idx     <= '0;
            pos     <= '0;
            dur     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
          end else begin
            // next note, or note 0 again when looping; phase restarts high
            idx     <= ld_idx;
            dur     <= ld_dur;
            pos     <= '0;
            piezo   <= tone_hi(ld_per, '0);
            piezo_n <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player: two instances (step 16 and a coarse step) checked
// every cycle against a time-based model of the note tables.
module tb_tune_player;

  logic       clk = 1'b0;
  logic       rst, loop, abort, go0, go1;
  logic       sel0;
  logic [1:0] sel1;
  logic [1:0] pz, pzn, bs, dn;

  always #5 clk = ~clk;

  tune_player u_d0 (
    .clk(clk), .rst(rst), .go(go0), .tune_sel(sel0),
    .loop(loop), .abort(abort), .piezo(pz[0]),
    .piezo_n(pzn[0]), .busy(bs[0]), .done(dn[0])
  );

  tune_player #(.NUM_TUNES(3), .FAST_SHIFT(16)) u_d1 (
    .clk(clk), .rst(rst), .go(go1), .tune_sel(sel1),
    .loop(loop), .abort(abort), .piezo(pz[1]),
    .piezo_n(pzn[1]), .busy(bs[1]), .done(dn[1])
  );

  int    errs = 0;
  int    checks = 0;
  int    per_t[2][6];
  int    dur_t[2][6];
  int    nn[2];
  int    steps[2];
  int    nt[2];
  bit    m_play[2];
  bit    m_done[2];
  int    m_tune[2];
  int    m_t[2];
  string tags[2][4];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int note_len(input int d, input int st);
    return (d + st - 1) / st;
  endfunction

  function automatic int pass_len(input int tn, input int st);
    int s;
    s = 0;
    for (int k = 0; k < nn[tn]; k++) s += note_len(dur_t[tn][k], st);
    return s;
  endfunction

  task automatic exp_tone(input int tn, input int st, input int t,
                          output bit p1, output bit p2);
    int o;
    bit hit;
    o = t; p1 = 1'b0; p2 = 1'b0; hit = 1'b0;
    for (int k = 0; k < nn[tn]; k++) begin
      if (!hit) begin
        int l;
        int p;
        l = note_len(dur_t[tn][k], st);
        if (o < l) begin
          hit = 1'b1;
          p = per_t[tn][k];
          if (p != 0) begin
            p1 = ((o % p) < (p + 1) / 2);
            p2 = !p1;
          end
        end else begin
          o -= l;
        end
      end
    end
  endtask

  task automatic tick();
    bit e_pz, e_pzn;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int g, s;
      g = (d == 0) ? int'(go0) : int'(go1);
      s = (d == 0) ? int'(sel0) : int'(sel1);
      if (rst || abort) begin
        m_play[d] = 1'b0;
        m_done[d] = 1'b0;
      end else if (!m_play[d]) begin
        m_done[d] = 1'b0;
        if (g != 0 && s < nt[d]) begin
          m_play[d] = 1'b1;
          m_tune[d] = s;
          m_t[d] = 0;
        end
      end else begin
        m_done[d] = 1'b0;
        if (m_t[d] + 1 == pass_len(m_tune[d], steps[d])) begin
          if (loop) m_t[d] = 0;
          else begin
            m_play[d] = 1'b0;
            m_done[d] = 1'b1;
          end
        end else begin
          m_t[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      e_pz = 1'b0;
      e_pzn = 1'b0;
      if (m_play[d]) exp_tone(m_tune[d], steps[d], m_t[d], e_pz, e_pzn);
      chk(tags[d][0], int'(bs[d]), int'(m_play[d]));
      chk(tags[d][1], int'(dn[d]), int'(m_done[d]));
      chk(tags[d][2], int'(pz[d]), int'(e_pz));
      chk(tags[d][3], int'(pzn[d]), int'(e_pzn));
    end
  endtask

  initial begin
    per_t[0] = '{31888, 23889, 18961, 15944, 18961, 15944};
    dur_t[0] = '{1 << 23, 1 << 23, 1 << 23, (1 << 23) + (1 << 22),
                 1 << 22, 1 << 24};
    per_t[1] = '{15944, 0, 15944, 0, 0, 0};
    dur_t[1] = '{1 << 22, 1 << 22, 1 << 22, 0, 0, 0};
    nn = '{6, 3};
    steps = '{16, 65536};
    nt = '{2, 3};
    for (int d = 0; d < 2; d++) begin
      m_play[d] = 1'b0;
      m_done[d] = 1'b0;
      m_tune[d] = 0;
      m_t[d] = 0;
      tags[d][0] = $sformatf("d%0d busy", d);
      tags[d][1] = $sformatf("d%0d done", d);
      tags[d][2] = $sformatf("d%0d piezo", d);
      tags[d][3] = $sformatf("d%0d piezo_n", d);
    end

    rst = 1'b1; loop = 1'b0; abort = 1'b0;
    go0 = 1'b0; go1 = 1'b0; sel0 = 1'b0; sel1 = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // tune 0 tone shape; stray go / tune_sel changes must not disturb it
    go0 = 1'b1; sel0 = 1'b0;
    tick();
    go0 = 1'b0;
    repeat (34000) begin
      go0 = ($urandom_range(0, 999) == 0);
      sel0 = 1'($urandom_range(0, 1));
      tick();
    end
    go0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // abort mid-note, then go and abort together
    go0 = 1'b1; sel0 = 1'b0;
    tick();
    go0 = 1'b0;
    repeat (1000) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (50) tick();
    go0 = 1'b1; abort = 1'b1;
    tick();
    go0 = 1'b0; abort = 1'b0;
    repeat (5) tick();

    // coarse instance: looping tune 1, then a full tune 0, then out of range
    loop = 1'b1; sel1 = 2'd1; go1 = 1'b1;
    tick();
    go1 = 1'b0;
    repeat (400) tick();
    loop = 1'b0;
    repeat (250) tick();
    sel1 = 2'd0; go1 = 1'b1;
    tick();
    go1 = 1'b0;
    repeat (950) tick();
    sel1 = 2'd3; go1 = 1'b1;
    tick();
    go1 = 1'b0;
    repeat (3) tick();

    repeat (20000) begin
      int r;
      r = $urandom_range(0, 2);
      sel1 = (r == 2) ? 2'd3 : 2'(r);
      go1 = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) loop = ~loop;
      abort = ($urandom_range(0, 2999) == 0);
      tick();
    end
    go1 = 1'b0; abort = 1'b0; loop = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
